vga_frame_sched: RTL
====================

Name: vga_frame_sched

Overview:
- Frame-level scheduler sitting between the CPU and the pixel frame reader (DMA) that feeds vga_display over Avalon-ST.
- On each vertical-blank pulse, applies any pending double-buffer swap.
- Reprograms the reader's base address, then issues its restart command over an Avalon-MM master.
- Exposes a small CPU-facing Avalon-MM CSR slave and a frame-done interrupt.

Parameters:
- MM_CSR_ADDR_WIDTH, 4: reader CSR address width (master side).
- MM_CSR_DATA_WIDTH, 32: reader CSR data width; also the slave data width.
- BASE_REG_ADDR, 1: reader CSR address of the frame base register.
- CMD_REG_ADDR, 0: reader CSR address of the command register (data 1 = restart).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- vblank_start  in  1  single-cycle pulse at start of vertical blanking, from the display timing generator.
- s_address  in  3  CPU CSR word address.
- s_write  in  1  CPU write strobe.
- s_writedata  in  32  CPU write data.
- s_read  in  1  CPU read strobe.
- s_readdata  out  32  read data, valid the cycle after s_read (fixed read latency 1).
- m_write  out  1  reader CSR write request.
- m_address  out  MM_CSR_ADDR_WIDTH  reader CSR address.
- m_writedata  out  MM_CSR_DATA_WIDTH  reader CSR data.
- m_waitrequest  in  1  reader stall.
- irq  out  1  level interrupt = irq_flag AND irq_en.

Behaviour:
- CSR map (slave, no waitrequest):
  - 0 CTRL rw: bit0 enable, bit1 irq_en.
  - 1 STATUS: bit0 swap_pending (ro), bit1 irq_flag (W1C), bit2 overrun (W1C).
  - 2 BACK_ADDR rw: bits[1:0] forced 0.
  - 3 SWAP wo: any write sets swap_pending.
  - 4 FRONT_ADDR ro.
  - 5 FRAME_COUNT ro: 16-bit, zero-extended.
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset values:
  - All registers 0; FRONT_ADDR 0, FRAME_COUNT 0.
  - m_write 0, m_address 0, m_writedata 0, s_readdata 0, irq 0.
  - FSM in IDLE.
- FSM states: IDLE, WR_BASE, WR_CMD.
- IDLE:
  - On vblank_start with enable=1, go to WR_BASE.
  - On the same edge: if swap_pending (value before any same-cycle SWAP write), FRONT_ADDR <= BACK_ADDR, swap_pending <= 0, irq_flag <= 1.
  - A SWAP write in the same cycle as vblank_start is kept pending for the next vblank.
- WR_BASE:
  - m_write=1, m_address=BASE_REG_ADDR, m_writedata=FRONT_ADDR (post-swap value).
  - Hold all three stable while m_waitrequest=1.
  - The write completes in the first cycle m_write=1 and m_waitrequest=0; then go to WR_CMD.
- WR_CMD:
  - Same handshake with m_address=CMD_REG_ADDR, m_writedata=1.
  - On completion: FRAME_COUNT += 1 (wraps 0xFFFF -> 0), go to IDLE.
  - m_write deasserts the cycle after completion.
- m_write is registered.
  - Minimum sequence is 4 cycles from vblank_start to IDLE when waitrequest=0: vblank, WR_BASE, WR_CMD, IDLE.
  - m_write is never asserted in IDLE.
- vblank_start outside IDLE: ignored for sequencing, sets overrun=1; no swap is applied.
- vblank_start with enable=0: no action, no swap, no count.
- Clearing enable mid-sequence: the current sequence still completes.
- BACK_ADDR written while swap_pending: the latest value is used at the swap.
- Writing BACK_ADDR during WR_BASE does not affect m_writedata, which shows FRONT_ADDR.
- W1C and a hardware set in the same cycle: set wins.
- Reset asserted mid-transaction: m_write low from the next edge, FSM to IDLE, all state cleared.

Test Plan:
- Reset, write CTRL=1, BACK_ADDR=0x0010_0000, SWAP; pulse vblank_start with m_waitrequest=0 -> m_write for 2 cycles: (addr 1, data 0x0010_0000), then (addr 0, data 1). FRONT_ADDR reads 0x0010_0000, FRAME_COUNT=1, STATUS.bit0=0.
- m_waitrequest held high 5 cycles in WR_BASE and 3 in WR_CMD -> address/data stable throughout, each write completes on the cycle waitrequest drops, m_write low afterwards.
- SWAP write coincident with vblank_start (pending was 0) -> FRONT_ADDR unchanged, swap_pending=1. The next vblank applies it.
- Second vblank_start 1 cycle after the first while m_waitrequest=1 -> STATUS.bit2=1, exactly one base write and one cmd write issued. Writing STATUS=0x4 clears overrun.
- CTRL=3 with a swap -> irq=1 after vblank. Writing STATUS=0x2 -> irq=0 next cycle. With CTRL=1 the same swap sets irq_flag but irq stays 0.
- Reset pulsed while in WR_CMD with waitrequest high -> m_write=0 after the reset edge. All CSR reads return 0 except enable-independent unmapped reads (also 0).

Source files
------------

// File: rtl/vga_frame_sched.sv
// rtl/vga_frame_sched.sv - vblank-driven double-buffer swap and frame reader restart
// Frame scheduler: CPU CSR slave, swap on vblank, then base + restart writes to the reader.
module vga_frame_sched #(
  parameter int MM_CSR_ADDR_WIDTH = 4,
  parameter int MM_CSR_DATA_WIDTH = 32,
  parameter int BASE_REG_ADDR     = 1,
  parameter int CMD_REG_ADDR      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vblank_start,
  input  logic [2:0]                   s_address,
  input  logic                         s_write,
  input  logic [MM_CSR_DATA_WIDTH-1:0] s_writedata,
  input  logic                         s_read,
  output logic [MM_CSR_DATA_WIDTH-1:0] s_readdata,
  output logic                         m_write,
  output logic [MM_CSR_ADDR_WIDTH-1:0] m_address,
  output logic [MM_CSR_DATA_WIDTH-1:0] m_writedata,
  input  logic                         m_waitrequest,
  output logic                         irq
);
  localparam int W = MM_CSR_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WR_BASE, WR_CMD} state_t;

  state_t                       state_q;
  logic                         enable_q, enable_d, irq_en_q, irq_en_d;
  logic                         swap_pending_q, swap_pending_d;
  logic                         irq_flag_q, irq_flag_d, overrun_q, overrun_d;
  logic [W-1:0]                 back_addr_q, back_addr_d, front_addr_q, front_addr_d;
  logic [W-1:0]                 s_readdata_q, s_readdata_d;
  logic [15:0]                  frame_count_q;
  logic                         m_write_q;
  logic [MM_CSR_ADDR_WIDTH-1:0] m_address_q;
  logic [W-1:0]                 m_writedata_q;
  logic                         go, do_swap, done, wr_status;

  always_comb begin
    go        = vblank_start && enable_q && (state_q == IDLE);
    do_swap   = go && swap_pending_q;
    done      = m_write_q && !m_waitrequest;
    wr_status = s_write && (s_address == 3'd1);

    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    if (s_write && (s_address == 3'd0)) begin
      enable_d = s_writedata[0];
      irq_en_d = s_writedata[1];
    end
    back_addr_d = back_addr_q;
    if (s_write && (s_address == 3'd2))
      back_addr_d = {s_writedata[W-1:2], 2'b00};

    // Hardware sets take priority over same-cycle CPU clears.
    swap_pending_d = (s_write && (s_address == 3'd3)) || (swap_pending_q && !do_swap);
    irq_flag_d     = do_swap || (irq_flag_q && !(wr_status && s_writedata[1]));
    overrun_d      = (vblank_start && (state_q != IDLE)) ||
                     (overrun_q && !(wr_status && s_writedata[2]));
    front_addr_d   = do_swap ? back_addr_q : front_addr_q;

    s_readdata_d = '0;
    if (s_read) begin
      case (s_address)
        3'd0:    s_readdata_d = {{(W-2){1'b0}}, irq_en_q, enable_q};
        3'd1:    s_readdata_d = {{(W-3){1'b0}}, overrun_q, irq_flag_q, swap_pending_q};
        3'd2:    s_readdata_d = back_addr_q;
        3'd4:    s_readdata_d = front_addr_q;
        3'd5:    s_readdata_d = W'(frame_count_q);
        default: s_readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      swap_pending_q <= 1'b0;
      irq_flag_q     <= 1'b0;
      overrun_q      <= 1'b0;
      back_addr_q    <= '0;
      front_addr_q   <= '0;
      s_readdata_q   <= '0;
    end else begin
      enable_q       <= enable_d;
      irq_en_q       <= irq_en_d;
      swap_pending_q <= swap_pending_d;
      irq_flag_q     <= irq_flag_d;
      overrun_q      <= overrun_d;
      back_addr_q    <= back_addr_d;
      front_addr_q   <= front_addr_d;
      s_readdata_q   <= s_readdata_d;
    end
  end

  // Master sequencer: base write carries the post-swap front address, then restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q       <= WR_BASE;
            m_write_q     <= 1'b1;
            m_address_q   <= MM_CSR_ADDR_WIDTH'(BASE_REG_ADDR);
            m_writedata_q <= front_addr_d;
          end
        end
        WR_BASE: begin
          if (done) begin
            state_q       <= WR_CMD;
            m_address_q   <= MM_CSR_ADDR_WIDTH'(CMD_REG_ADDR);
            m_writedata_q <= W'(1);
          end
        end
        WR_CMD: begin
          if (done) begin
            state_q       <= IDLE;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_readdata  = s_readdata_q;
  assign m_write     = m_write_q;
  assign m_address   = m_address_q;
  assign m_writedata = m_writedata_q;
  assign irq         = irq_flag_q && irq_en_q;

endmodule
